// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: programmable divider, CPOL/CPHA, bit count, shift/sample strobes.
// Define SPI_SCLK_GAP_EN to hold busy_o for GAP_CYCLES idle cycles after the final edge.
module spi_sclk_gen #(
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             cpol_i,
  input  logic             cpha_i,
  input  logic [DIV_W-1:0] clk_div_i,
  input  logic [CNT_W-1:0] num_bits_i,
  output logic             sclk_o,
  output logic             shift_o,
  output logic             sample_o,
  output logic             busy_o,
  output logic             done_o
);

`ifdef SPI_SCLK_GAP_EN
  typedef enum logic [1:0] {StIdle, StRun, StGap} state_e;

  localparam int unsigned GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GapLast = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
`else
  typedef enum logic [1:0] {StIdle, StRun} state_e;
`endif

  state_e           state_q, state_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] nbits_q, nbits_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W:0]   edge_cnt_q, edge_cnt_d;
  logic             sclk_q, sclk_d;
  logic             shift_q, shift_d;
  logic             sample_q, sample_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W:0] edge_nxt;
  logic [CNT_W:0] edge_last;
  logic           last_edge;
  logic           div_hit;
  logic           leading;

  assign edge_nxt  = edge_cnt_q + 1'b1;
  assign edge_last = {nbits_q, 1'b0};
  assign last_edge = (edge_nxt == edge_last);
  assign div_hit   = (div_cnt_q == div_q);
  // Edges are 1-based, so odd edge numbers are leading edges.
  assign leading   = edge_nxt[0];

  always_comb begin
    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    div_d      = div_q;
    nbits_d    = nbits_q;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sclk_d     = sclk_q;
    shift_d    = 1'b0;
    sample_d   = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef SPI_SCLK_GAP_EN
    gap_cnt_d  = gap_cnt_q;
`endif

    case (state_q)
      StIdle: begin
        cpol_d = cpol_i;
        sclk_d = cpol_i;
        if (start_i && !abort_i) begin
          cpha_d     = cpha_i;
          div_d      = clk_div_i;
          nbits_d    = num_bits_i;
          div_cnt_d  = '0;
          edge_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = StRun;
        end
      end

      StRun: begin
        if (nbits_q == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          // First cycle of a CPHA=0 transfer: present bit 0 before the leading edge.
          if (!cpha_q && (edge_cnt_q == '0) && (div_cnt_q == '0)) begin
            shift_d = 1'b1;
          end
          if (div_hit) begin
            div_cnt_d  = '0;
            edge_cnt_d = edge_nxt;
            sclk_d     = ~sclk_q;
            if (leading) begin
              if (cpha_q) shift_d = 1'b1;
              else        sample_d = 1'b1;
            end else begin
              if (cpha_q)          sample_d = 1'b1;
              else if (!last_edge) shift_d = 1'b1;
            end
            if (last_edge) begin
              sclk_d = cpol_q;
`ifdef SPI_SCLK_GAP_EN
              gap_cnt_d = '0;
              state_d   = StGap;
`else
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = StIdle;
`endif
            end
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end
        end
      end

`ifdef SPI_SCLK_GAP_EN
      StGap: begin
        sclk_d = cpol_q;
        if (gap_cnt_q == GapW'(GapLast)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
`endif

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase

    // Abort wins over any in-flight edge or completion; no done pulse.
    if (abort_i && (state_q != StIdle)) begin
      state_d  = StIdle;
      busy_d   = 1'b0;
      sclk_d   = cpol_q;
      shift_d  = 1'b0;
      sample_d = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= StIdle;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      div_q      <= '0;
      nbits_q    <= '0;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= 1'b0;
      shift_q    <= 1'b0;
      sample_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SPI_SCLK_GAP_EN
      gap_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      div_q      <= div_d;
      nbits_q    <= nbits_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sclk_q     <= sclk_d;
      shift_q    <= shift_d;
      sample_q   <= sample_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef SPI_SCLK_GAP_EN
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  assign sclk_o   = sclk_q;
  assign shift_o  = shift_q;
  assign sample_o = sample_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Randomised bench for spi_sclk_gen against a closed-form timing model, plus literal waveform pins.
module tb_spi_sclk_gen;
  localparam int unsigned DivW      = 8;
  localparam int unsigned CntW      = 6;
  localparam int unsigned GapCycles = 2;
`ifdef SPI_SCLK_GAP_EN
  localparam int GapX = GapCycles;
`else
  localparam int GapX = 0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start, abort, cpol, cpha;
  logic [DivW-1:0] clk_div;
  logic [CntW-1:0] num_bits;
  logic            sclk, shift, sample, busy, done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_sclk_gen #(
    .DIV_W      (DivW),
    .CNT_W      (CntW),
    .GAP_CYCLES (GapCycles)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .start_i    (start),
    .abort_i    (abort),
    .cpol_i     (cpol),
    .cpha_i     (cpha),
    .clk_div_i  (clk_div),
    .num_bits_i (num_bits),
    .sclk_o     (sclk),
    .shift_o    (shift),
    .sample_o   (sample),
    .busy_o     (busy),
    .done_o     (done)
  );

  // Outputs d cycles after the accepting edge, as {sclk, shift, sample, busy, done}.
  function automatic logic [4:0] model_out(int d, int n, int p, bit cp, bit ph);
    int  e_tot, fin, k;
    bit  lead;
    logic sc, sh, sa;
    e_tot = 2 * n * p;
    fin   = (n == 0) ? 1 : e_tot + GapX;
    sh = 1'b0;
    sa = 1'b0;
    if (n == 0 || d > e_tot) begin
      sc = cp;
    end else begin
      k  = d / p;
      sc = cp ^ k[0];
      if (d % p == 0) begin
        lead = k[0];
        if (ph) begin
          sh = lead;
          sa = !lead;
        end else begin
          sa = lead;
          sh = !lead && (k != 2 * n);
        end
      end
      if (!ph && d == 1) sh = 1'b1;
    end
    return {sc, sh, sa, (d < fin), (d == fin)};
  endfunction

  function automatic bit model_end(int d, int n, int p);
    return (n == 0) ? (d == 1) : (d == 2 * n * p + GapX);
  endfunction

  logic [4:0] exp_q;
  bit         m_act;
  int         m_d, m_n, m_p;
  bit         m_cpol, m_cpha;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q <= '0;
      m_act <= 1'b0;
      m_d   <= 0;
    end else if (m_act) begin
      if (abort) begin
        exp_q <= {m_cpol, 4'b0000};
        m_act <= 1'b0;
      end else begin
        exp_q <= model_out(m_d + 1, m_n, m_p, m_cpol, m_cpha);
        m_d   <= m_d + 1;
        if (model_end(m_d + 1, m_n, m_p)) m_act <= 1'b0;
      end
    end else if (start && !abort) begin
      exp_q  <= {cpol, 4'b0010};
      m_act  <= 1'b1;
      m_d    <= 0;
      m_cpol <= cpol;
      m_cpha <= cpha;
      m_n    <= int'(num_bits);
      m_p    <= int'(clk_div) + 1;
    end else begin
      exp_q <= {cpol, 4'b0000};
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if ({sclk, shift, sample, busy, done} !== exp_q) begin
        failures++;
        $display("FAIL cycle_model t=%0t got sclk/shift/sample/busy/done=%b want=%b",
                 $time, {sclk, shift, sample, busy, done}, exp_q);
      end
    end
  end

  task automatic check_vec(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    start = 1'b0;
    abort = 1'b0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle busy got=%b want=0", busy);
    end
  endtask

  task automatic capture(input bit cp, input bit ph, input int dv, input int nb, input int len,
                         output logic [15:0] v_sclk, output logic [15:0] v_shift,
                         output logic [15:0] v_sample, output logic [15:0] v_busy,
                         output logic [15:0] v_done);
    v_sclk = '0; v_shift = '0; v_sample = '0; v_busy = '0; v_done = '0;
    @(negedge clk);
    cpol = cp; cpha = ph; clk_div = DivW'(dv); num_bits = CntW'(nb);
    start = 1'b1;
    for (int d = 0; d <= len; d++) begin
      @(negedge clk);
      start = 1'b0;
      v_sclk[d] = sclk; v_shift[d] = shift; v_sample[d] = sample;
      v_busy[d] = busy; v_done[d] = done;
    end
  endtask

  initial begin
    logic [15:0] vs, vh, va, vb, vd;
    int tog, dones, samples;
    logic prev;

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; cpol = 1'b0; cpha = 1'b0;
    clk_div = '0; num_bits = '0;
    repeat (3) @(negedge clk);
    check_vec("reset_outputs", 16'({sclk, shift, sample, busy, done}), 16'h0000);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

`ifndef SPI_SCLK_GAP_EN
    capture(1'b0, 1'b0, 1, 2, 9, vs, vh, va, vb, vd);
    check_vec("mode0_sclk", vs, 16'h00CC);
    check_vec("mode0_shift", vh, 16'h0012);
    check_vec("mode0_sample", va, 16'h0044);
    check_vec("mode0_busy", vb, 16'h00FF);
    check_vec("mode0_done", vd, 16'h0100);
    wait_idle();

    capture(1'b1, 1'b1, 0, 3, 7, vs, vh, va, vb, vd);
    check_vec("mode3_sclk", vs, 16'h00D5);
    check_vec("mode3_shift", vh, 16'h002A);
    check_vec("mode3_sample", va, 16'h0054);
    check_vec("mode3_busy", vb, 16'h003F);
    check_vec("mode3_done", vd, 16'h0040);
    wait_idle();
`else
    capture(1'b0, 1'b0, 0, 1, 6, vs, vh, va, vb, vd);
    check_vec("gap_sclk", vs, 16'h0002);
    check_vec("gap_shift", vh, 16'h0002);
    check_vec("gap_sample", va, 16'h0002);
    check_vec("gap_busy", vb, 16'h000F);
    check_vec("gap_done", vd, 16'h0010);
    wait_idle();
`endif

    // Second start during a div=3, N=1 transfer must be ignored.
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b1; clk_div = 8'd3; num_bits = 6'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prev = sclk; tog = 0; dones = 0;
    for (int d = 1; d <= 12 + GapX; d++) begin
      @(negedge clk);
      if (sclk !== prev) tog++;
      prev = sclk;
      if (done === 1'b1) dones++;
      start = (d == 2);
    end
    start = 1'b0;
    check_vec("busy_start_edges", 16'(tog), 16'd2);
    check_vec("busy_start_dones", 16'(dones), 16'd1);
    wait_idle();

    // N=0: done one cycle after accept, sclk never moves.
    capture(1'b0, 1'b0, 2, 0, 3, vs, vh, va, vb, vd);
    check_vec("n0_sclk", vs, 16'h0000);
    check_vec("n0_busy_done", {vb[7:0], vd[7:0]}, 16'h0102);
    wait_idle();

    // Abort after edge 3 of a div=2, N=4 transfer.
    @(negedge clk);
    cpol = 1'b1; cpha = 1'b0; clk_div = 8'd2; num_bits = 6'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prev = sclk; tog = 0;
    for (int d = 1; d <= 9; d++) begin
      @(negedge clk);
      if (sclk !== prev) tog++;
      prev = sclk;
    end
    check_vec("abort_edges_before", 16'(tog), 16'd3);
    abort = 1'b1;
    @(negedge clk);
    check_vec("abort_next_cycle", 16'({busy, sclk, shift, sample, done}), 16'b01000);
    abort = 1'b0; clk_div = 8'd0; num_bits = 6'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_vec("abort_restart_busy", 16'(busy), 16'd1);
    wait_idle();

    // Random traffic: starts, aborts and config churn checked cycle by cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start   = ($urandom_range(0, 3) == 0);
      abort   = ($urandom_range(0, 39) == 0);
      cpol    = 1'($urandom_range(0, 1));
      cpha    = 1'($urandom_range(0, 1));
      clk_div = DivW'($urandom_range(0, 3));
      num_bits = ($urandom_range(0, 15) == 0) ? CntW'($urandom_range(0, 63))
                                              : CntW'($urandom_range(0, 4));
    end
    wait_idle();

    // Asynchronous reset in the middle of a div=5, N=8 transfer.
    @(negedge clk);
    cpol = 1'b1; cpha = 1'b0; clk_div = 8'd5; num_bits = 6'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check_vec("busy_before_reset", 16'(busy), 16'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_vec("async_reset", 16'({sclk, shift, sample, busy, done}), 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    cpol = 1'b0; cpha = 1'b1; clk_div = 8'd5; num_bits = 6'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prev = sclk; tog = 0; dones = 0; samples = 0;
    for (int d = 1; d <= 16 * 6 + 4 + GapX; d++) begin
      @(negedge clk);
      if (sclk !== prev) tog++;
      prev = sclk;
      if (done === 1'b1) dones++;
      if (sample === 1'b1) samples++;
    end
    check_vec("post_reset_edges", 16'(tog), 16'd16);
    check_vec("post_reset_samples", 16'(samples), 16'd8);
    check_vec("post_reset_dones", 16'(dones), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
